cnn16_mem_responder: RTL and testbench
======================================

// Module: cnn16_mem_responder
// PURPOSE
//  Memory-side responder for the CNN16 datapath memory interface (address / to_memory / from_memory).
//  Holds the 4K x 16 unified program + image/kernel store and serves one datapath access at a time,
//  with configurable read latency and a mem_ready completion pulse.
//  Has a secondary host port for preloading and dumping memory (images, kernels, programs) around CNN16 runs.
// PARAMETERS
//  ADDR_W  12    address width; matches the datapath address bus
//  DATA_W  16    word width
//  DEPTH   4096  implemented words, DEPTH <= 2**ADDR_W
//  RD_LAT  1     read latency in cycles, legal range 1..4
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  cpu_rd       in   1       datapath read strobe, one-cycle pulse
//  cpu_wr       in   1       datapath write strobe, one-cycle pulse
//  address      in   ADDR_W  datapath address (AR)
//  to_memory    in   DATA_W  datapath write data (bus)
//  from_memory  out  DATA_W  read data to the datapath; held until the next CPU read completes
//  mem_ready    out  1       one-cycle completion pulse for a CPU read or write
//  host_valid   in   1       host request valid
//  host_ready   out  1       host request accepted this cycle (valid & ready = transfer)
//  host_we      in   1       1 = write, 0 = read
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_rvalid  out  1       one-cycle pulse; host_rdata is valid
//  host_rdata   out  DATA_W  host read data; held until the next host read completes
//  busy         out  1       high while not IDLE
//  err_overlap  out  1       sticky; a CPU strobe arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; any in-flight access is dropped with no ready/rvalid pulse.
//    Array contents are NOT reset; writes completed before rst are retained.
//  FSM states: IDLE, CPU_RD, HOST_RD.
//  host_ready is combinational: (state == IDLE) & ~cpu_rd & ~cpu_wr.
//  Arbitration in IDLE:
//    CPU request always beats host.
//    cpu_wr & cpu_rd together -> write only; the read is dropped.
//  Writes (CPU or host):
//    Array is written at the edge that ends the request cycle n.
//    CPU write -> mem_ready = 1 in cycle n+1.
//    Host write -> no rvalid pulse.
//    FSM stays in IDLE.
//  Reads:
//    Address is captured in cycle n; FSM -> CPU_RD / HOST_RD; a latency counter is loaded with RD_LAT.
//    In cycle n+RD_LAT: from_memory / host_rdata are updated and mem_ready / host_rvalid are high.
//    FSM is IDLE again in that same cycle, so a new request is accepted there.
//    Peak rate: one read per RD_LAT cycles.
//  Strobes outside IDLE:
//    CPU strobe -> ignored; err_overlap set (cleared only by rst).
//    Host requests -> stalled, because host_ready is low.
//  Out of range (address >= DEPTH):
//    Write is discarded; read returns 0.
//    The ready/rvalid pulse and timing are unchanged.
//  Addresses are not wrapped or incremented internally.
//    The top address 2**ADDR_W-1 is a normal location when DEPTH = 4096.
//  from_memory is registered, never combinational from the array.
//  A read following a write to the same address returns the new data.
//  Read-modify-write is not supported.
// TESTING
//  1. Host wr 0x010 = 0xBEEF, then host rd 0x010 (RD_LAT=1) -> host_rvalid 1 cycle later, host_rdata = 0xBEEF.
//  2. RD_LAT=2, cpu_rd addr 0x010 in cycle n -> mem_ready only in cycle n+2, from_memory = 0xBEEF; busy high in n+1.
//  3. cpu_wr 0xFFF = 0x1234, then cpu_rd 0xFFF -> mem_ready after write, then from_memory = 0x1234; top address OK.
//  4. cpu_rd and host_valid in the same cycle -> host_ready = 0, CPU served first; host accepted when IDLE again.
//  5. cpu_rd, then cpu_rd again while in CPU_RD (RD_LAT=3) -> second ignored, one mem_ready only, err_overlap = 1.
//  6. rst asserted in CPU_RD -> no mem_ready, from_memory = 0, busy = 0; 0x010 still reads 0xBEEF after reset.

Source files
------------

// File: rtl/cnn16_mem_responder.sv
// rtl/cnn16_mem_responder.sv - CNN16 memory responder: 4K x 16 store, datapath port plus host preload/dump port
module cnn16_mem_responder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] from_memory,
    output logic              mem_ready,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              err_overlap
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_RD  = 2'd1,
        S_HOST_RD = 2'd2
    } state_t;

    localparam logic [2:0]      LAT     = 3'(RD_LAT);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nx;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle, cpu_req;
    logic              cpu_wr_go, cpu_rd_go, host_go, host_wr_go, host_rd_go;
    logic              rd_done, cpu_fin, host_fin;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data, rd_word;
    logic              rd_in_range, wr_in_range, wr_en;

    always_comb begin
        idle        = (state == S_IDLE);
        cpu_req     = cpu_rd | cpu_wr;
        host_ready  = idle & ~cpu_req;
        busy        = ~idle;
        // A combined read+write strobe is treated as a write; the read is dropped.
        cpu_wr_go   = idle & cpu_wr;
        cpu_rd_go   = idle & cpu_rd & ~cpu_wr;
        host_go     = host_valid & host_ready;
        host_wr_go  = host_go & host_we;
        host_rd_go  = host_go & ~host_we;
        // lat_cnt holds RD_LAT in the first wait cycle; the data edge is the one where it reads 2.
        rd_done     = ~idle & (lat_cnt == 3'd2);
        cpu_fin     = (RD_LAT == 1) ? cpu_rd_go  : ((state == S_CPU_RD)  & rd_done);
        host_fin    = (RD_LAT == 1) ? host_rd_go : ((state == S_HOST_RD) & rd_done);
        rd_addr     = idle ? (cpu_rd_go ? address : host_addr) : addr_q;
        rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
        rd_word     = rd_in_range ? mem[rd_addr] : '0;
        wr_addr     = cpu_wr_go ? address : host_addr;
        wr_data     = cpu_wr_go ? to_memory : host_wdata;
        wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
        wr_en       = ~rst & (cpu_wr_go | host_wr_go) & wr_in_range;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (RD_LAT > 1) begin
                    if (cpu_rd_go)
                        state_nx = S_CPU_RD;
                    else if (host_rd_go)
                        state_nx = S_HOST_RD;
                end
            end
            S_CPU_RD, S_HOST_RD: begin
                if (rd_done)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The array is deliberately left out of reset so preloaded contents survive a datapath reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            addr_q      <= '0;
            from_memory <= '0;
            mem_ready   <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            err_overlap <= 1'b0;
        end else begin
            state       <= state_nx;
            mem_ready   <= cpu_wr_go | cpu_fin;
            host_rvalid <= host_fin;
            if (cpu_fin)
                from_memory <= rd_word;
            if (host_fin)
                host_rdata <= rd_word;
            if (cpu_rd_go | host_rd_go) begin
                addr_q  <= rd_addr;
                lat_cnt <= LAT;
            end else if (!idle) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (!idle && cpu_req)
                err_overlap <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn16_mem_responder.sv
// tb/tb_cnn16_mem_responder.sv - self-checking bench for cnn16_mem_responder across three latency/depth variants
module tb_cnn16_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, host_valid = 1'b0, host_we = 1'b0;
    logic [11:0] address = '0, host_addr = '0;
    logic [15:0] to_memory = '0, host_wdata = '0;

    logic [15:0] fm [3];
    logic [15:0] hrd [3];
    logic        mr [3], hr [3], hrv [3], bsy [3], eo [3];

    always #5 clk = ~clk;

    cnn16_mem_responder #(.RD_LAT(1), .DEPTH(4096)) u_l1 (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .address(address),
        .to_memory(to_memory), .from_memory(fm[0]), .mem_ready(mr[0]),
        .host_valid(host_valid), .host_ready(hr[0]), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(hrv[0]), .host_rdata(hrd[0]),
        .busy(bsy[0]), .err_overlap(eo[0]));

    cnn16_mem_responder #(.RD_LAT(2), .DEPTH(3000)) u_l2 (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .address(address),
        .to_memory(to_memory), .from_memory(fm[1]), .mem_ready(mr[1]),
        .host_valid(host_valid), .host_ready(hr[1]), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(hrv[1]), .host_rdata(hrd[1]),
        .busy(bsy[1]), .err_overlap(eo[1]));

    cnn16_mem_responder #(.RD_LAT(3), .DEPTH(4096)) u_l3 (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .address(address),
        .to_memory(to_memory), .from_memory(fm[2]), .mem_ready(mr[2]),
        .host_valid(host_valid), .host_ready(hr[2]), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(hrv[2]), .host_rdata(hrd[2]),
        .busy(bsy[2]), .err_overlap(eo[2]));

    // Reference model: per-variant word array plus the cycle numbers at which things are due.
    int          lat [3] = '{1, 2, 3};
    int          dep [3] = '{4096, 3000, 4096};
    logic [15:0] mm [3][4096];
    int          cyc = 0;
    int          free_at [3], rdy_at [3], hrv_at [3];
    logic [15:0] pend_fm [3], pend_hrd [3], exp_fm [3], exp_hrd [3];
    bit          exp_err [3], err_nx [3], rst_pend [3], exp_hr [3], hr_obs [3];
    int          total = 0;
    int          bad = 0;

    task automatic step(input bit r, input bit crd, input bit cwr, input logic [11:0] a,
                        input logic [15:0] d, input bit hv, input bit hwe,
                        input logic [11:0] ha, input logic [15:0] hd);
        rst = r; cpu_rd = crd; cpu_wr = cwr; address = a; to_memory = d;
        host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hd;
        #1;
        for (int k = 0; k < 3; k++) begin
            hr_obs[k] = hr[k];
            exp_hr[k] = (cyc >= free_at[k]) && !crd && !cwr;
            if (r) begin
                rst_pend[k] = 1'b1;
            end else if (cyc >= free_at[k]) begin
                if (cwr) begin
                    if (int'(a) < dep[k]) mm[k][a] = d;
                    rdy_at[k] = cyc + 1;
                end else if (crd) begin
                    pend_fm[k] = (int'(a) < dep[k]) ? mm[k][a] : 16'h0;
                    rdy_at[k]  = cyc + lat[k];
                    free_at[k] = cyc + lat[k];
                end else if (hv) begin
                    if (hwe) begin
                        if (int'(ha) < dep[k]) mm[k][ha] = hd;
                    end else begin
                        pend_hrd[k] = (int'(ha) < dep[k]) ? mm[k][ha] : 16'h0;
                        hrv_at[k]   = cyc + lat[k];
                        free_at[k]  = cyc + lat[k];
                    end
                end
            end else if (crd || cwr) begin
                err_nx[k] = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst_pend[k]) begin
                rdy_at[k] = -1; hrv_at[k] = -1; free_at[k] = cyc;
                exp_fm[k] = '0; exp_hrd[k] = '0; pend_fm[k] = '0;
                exp_err[k] = 1'b0; err_nx[k] = 1'b0; rst_pend[k] = 1'b0;
            end else begin
                if (rdy_at[k] == cyc) exp_fm[k] = pend_fm[k];
                if (hrv_at[k] == cyc) exp_hrd[k] = pend_hrd[k];
                if (err_nx[k]) exp_err[k] = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        logic [35:0] got;
        for (int k = 0; k < 3; k++) begin
            free_at[k] = 0; rdy_at[k] = -1; hrv_at[k] = -1;
        end
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(1);
        #1;
        for (int k = 0; k < 3; k++) begin
            got = {mr[k], hrv[k], bsy[k], eo[k], fm[k], hrd[k]};
            total++;
            if (got !== 36'h0) begin
                $display("FAIL reset_outputs k=%0d got %h want 0", k, got);
                bad++;
            end
            total++;
            if (hr[k] !== 1'b1) begin
                $display("FAIL reset_host_ready k=%0d got %b want 1", k, hr[k]);
                bad++;
            end
        end
        for (int a = 0; a < 4096; a++)
            step(0, 0, 0, '0, '0, 1, 1, 12'(a), 16'(a) ^ 16'h5A5A);
    endtask

    task automatic test_host_wr_rd();
        step(0, 0, 0, '0, '0, 1, 1, 12'h010, 16'hBEEF);
        step(0, 0, 0, '0, '0, 1, 0, 12'h010, '0);
        total++;
        if (hrv[0] !== 1'b1 || hrd[0] !== 16'hBEEF) begin
            $display("FAIL host_rd_l1 got rvalid=%b data=%h want 1 beef", hrv[0], hrd[0]);
            bad++;
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (hr_obs[k] !== 1'b1) begin
                $display("FAIL host_rd_accept k=%0d got %b want 1", k, hr_obs[k]);
                bad++;
            end
        end
        idle(3);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (hrd[k] !== 16'hBEEF) begin
                $display("FAIL host_rd_data k=%0d got %h want beef", k, hrd[k]);
                bad++;
            end
        end
    endtask

    task automatic test_cpu_latency();
        step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
        total++;
        if ({mr[0], mr[1], bsy[1], bsy[2]} !== 4'b1011 || fm[0] !== 16'hBEEF) begin
            $display("FAIL lat_n1 got rdy/busy=%b fm0=%h want 1011 beef",
                     {mr[0], mr[1], bsy[1], bsy[2]}, fm[0]);
            bad++;
        end
        idle(1);
        total++;
        if ({mr[0], mr[1], mr[2], bsy[1], bsy[2]} !== 5'b01001 || fm[1] !== 16'hBEEF) begin
            $display("FAIL lat_n2 got rdy/busy=%b fm1=%h want 01001 beef",
                     {mr[0], mr[1], mr[2], bsy[1], bsy[2]}, fm[1]);
            bad++;
        end
        idle(1);
        total++;
        if ({mr[1], mr[2], bsy[2]} !== 3'b010 || fm[2] !== 16'hBEEF) begin
            $display("FAIL lat_n3 got rdy/busy=%b fm2=%h want 010 beef",
                     {mr[1], mr[2], bsy[2]}, fm[2]);
            bad++;
        end
    endtask

    task automatic test_top_addr();
        step(0, 0, 1, 12'hFFF, 16'h1234, 0, 0, '0, '0);
        total++;
        if ({mr[0], mr[1], mr[2]} !== 3'b111) begin
            $display("FAIL top_wr_ready got %b want 111", {mr[0], mr[1], mr[2]});
            bad++;
        end
        step(0, 1, 0, 12'hFFF, '0, 0, 0, '0, '0);
        idle(3);
        total++;
        if (fm[0] !== 16'h1234 || fm[1] !== 16'h0000 || fm[2] !== 16'h1234) begin
            $display("FAIL top_rd_data got %h %h %h want 1234 0000 1234", fm[0], fm[1], fm[2]);
            bad++;
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] pat [3];
        logic [3:0] want [3];
        want = '{4'b0111, 4'b0010, 4'b0001};
        pat = '{4'b0, 4'b0, 4'b0};
        step(0, 1, 0, 12'h010, '0, 1, 0, 12'h011, '0);
        for (int k = 0; k < 3; k++) pat[k][3] = hr_obs[k];
        for (int i = 2; i >= 0; i--) begin
            step(0, 0, 0, '0, '0, 1, 0, 12'h011, '0);
            for (int k = 0; k < 3; k++) pat[k][i] = hr_obs[k];
        end
        idle(4);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pat[k] !== want[k] || hrd[k] !== 16'h5A4B || fm[k] !== 16'hBEEF) begin
                $display("FAIL arb k=%0d got ready=%b hrd=%h fm=%h want %b 5a4b beef",
                         k, pat[k], hrd[k], fm[k], want[k]);
                bad++;
            end
        end
    endtask

    task automatic test_overlap();
        int pulses [3];
        pulses = '{0, 0, 0};
        step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) pulses[k] += int'(mr[k]);
        step(0, 1, 0, 12'h020, '0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) pulses[k] += int'(mr[k]);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            for (int k = 0; k < 3; k++) pulses[k] += int'(mr[k]);
        end
        total++;
        if ({eo[0], eo[1], eo[2]} !== 3'b011 || pulses[2] != 1 || pulses[0] != 2) begin
            $display("FAIL overlap got err=%b pulses=%0d/%0d want 011 2/1",
                     {eo[0], eo[1], eo[2]}, pulses[0], pulses[2]);
            bad++;
        end
        total++;
        if (fm[0] !== 16'h5A7A || fm[1] !== 16'hBEEF || fm[2] !== 16'hBEEF) begin
            $display("FAIL overlap_data got %h %h %h want 5a7a beef beef", fm[0], fm[1], fm[2]);
            bad++;
        end
    endtask

    task automatic test_reset_in_read();
        logic [35:0] got;
        int          seen;
        step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            got = {mr[k], hrv[k], bsy[k], eo[k], fm[k], hrd[k]};
            total++;
            if (got !== 36'h0) begin
                $display("FAIL rst_in_read k=%0d got %h want 0", k, got);
                bad++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            seen += int'(mr[1]) + int'(mr[2]);
        end
        total++;
        if (seen != 0) begin
            $display("FAIL rst_drop got %0d ready pulses want 0", seen);
            bad++;
        end
        step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
        idle(3);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (fm[k] !== 16'hBEEF) begin
                $display("FAIL rst_retain k=%0d got %h want beef", k, fm[k]);
                bad++;
            end
        end
    endtask

    task automatic test_random();
        bit          r, crd, cwr, hv, hwe;
        logic [11:0] a, ha;
        logic [36:0] got, want;
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            crd = ($urandom_range(0, 3) == 0);
            cwr = ($urandom_range(0, 5) == 0);
            hv  = ($urandom_range(0, 1) == 1);
            hwe = ($urandom_range(0, 1) == 1);
            a   = ($urandom_range(0, 3) == 0) ? 12'(4095 - $urandom_range(0, 3)) : 12'($urandom);
            ha  = ($urandom_range(0, 3) == 0) ? 12'(2998 + $urandom_range(0, 3)) : 12'($urandom);
            step(r, crd, cwr, a, 16'($urandom), hv, hwe, ha, 16'($urandom));
            for (int k = 0; k < 3; k++) begin
                if (!r) begin
                    total++;
                    if (hr_obs[k] !== exp_hr[k]) begin
                        $display("FAIL rnd_host_ready k=%0d cyc=%0d got %b want %b",
                                 k, cyc, hr_obs[k], exp_hr[k]);
                        bad++;
                    end
                end
                got  = {1'b0, mr[k], hrv[k], bsy[k], eo[k], fm[k], hrd[k]};
                want = {1'b0, 1'(rdy_at[k] == cyc), 1'(hrv_at[k] == cyc), 1'(cyc < free_at[k]),
                        exp_err[k], exp_fm[k], exp_hrd[k]};
                total++;
                if (got !== want) begin
                    $display("FAIL rnd_outputs k=%0d cyc=%0d got %h want %h", k, cyc, got, want);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_host_wr_rd();
        test_cpu_latency();
        test_top_addr();
        test_arbitration();
        test_overlap();
        test_reset_in_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
